// File: rtl/zero_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zero_pkg
// Description : Shared definitions for the zero-countdown timer slice:
//               FSM state encodings and the default counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package zero_pkg;

    // Default counter width for the timer and the zero detector
    localparam int c_DEFAULT_WIDTH = 8;

    // Two-state timer FSM; the done pulse is a separate registered flag
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage : zero_pkg
`default_nettype wire

// File: rtl/zero_det.sv
`default_nettype none
// ============================================================================
// Module      : zero_det
// Description : Combinational WIDTH-bit all-zero detector.
//               i_value  [WIDTH-1:0]  value under test
//               o_zero                1 when every bit of i_value is 0
// Revision    : 1.0 - initial release
// ============================================================================
module zero_det
    import zero_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    assign o_zero = ~(|i_value);

endmodule : zero_det
`default_nettype wire

// File: rtl/zero_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : zero_countdown_timer
// Description : Loadable down-counter with programmable tick prescaler.
//               Counts a WIDTH-bit value down to zero, flags zero with a
//               level output and a one-cycle done pulse.
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   load       in   1      capture load_val into counter and reload register
//   load_val   in   WIDTH  value to load
//   start      in   1      begin counting from IDLE
//   pause      in   1      hold counter and prescaler while running
//   count_out  out  WIDTH  current count (registered)
//   zero_out   out  1      count_out == 0
//   done       out  1      one-cycle pulse when the count reaches zero
//   busy       out  1      1 while running
// Build option: AUTO_RELOAD_EN - on reaching zero, reload the count from the
//               reload register on the next tick and keep running.
// Revision    : 1.0 - initial release
// ============================================================================
module zero_countdown_timer
    import zero_pkg::*;
#(
    parameter int WIDTH    = c_DEFAULT_WIDTH,
    parameter int TICK_DIV = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    output logic [WIDTH-1:0] count_out,
    output logic             zero_out,
    output logic             done,
    output logic             busy
);

    // Prescaler needs at least one bit even when TICK_DIV == 1
    localparam int                   c_PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_PRESC_W-1:0] c_PRESC_ONE  = c_PRESC_W'(1);
    localparam logic [WIDTH-1:0]     c_COUNT_ONE  = WIDTH'(1);

    state_t                 r_state_q, w_state_d;
    logic [WIDTH-1:0]       r_count_q, w_count_d;
    logic [WIDTH-1:0]       r_reload_q, w_reload_d;
    logic [c_PRESC_W-1:0]   r_presc_q, w_presc_d;
    logic                   r_done_q, w_done_d;
    logic                   w_tick;

    assign w_tick = (r_presc_q == c_PRESC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q  <= ST_IDLE;
            r_count_q  <= '0;
            r_reload_q <= '0;
            r_presc_q  <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_count_q  <= w_count_d;
            r_reload_q <= w_reload_d;
            r_presc_q  <= w_presc_d;
            r_done_q   <= w_done_d;
        end
    end

    // Priority: load > start > tick/decrement
    always_comb begin
        w_state_d  = r_state_q;
        w_count_d  = r_count_q;
        w_reload_d = r_reload_q;
        w_presc_d  = r_presc_q;
        w_done_d   = 1'b0;

        if (load) begin
            w_count_d  = load_val;
            w_reload_d = load_val;
            w_presc_d  = '0;
            w_state_d  = ST_IDLE;
        end else if (r_state_q == ST_IDLE) begin
            if (start) begin
                if (r_count_q != '0) begin
                    w_state_d = ST_RUN;
                    w_presc_d = '0;
                end else begin
                    // Already at zero: report completion without running
                    w_done_d = 1'b1;
                end
            end
        end else if (!pause) begin
            if (w_tick) begin
                w_presc_d = '0;
                if (r_count_q == c_COUNT_ONE) begin
                    w_count_d = '0;
                    w_done_d  = 1'b1;
`ifdef AUTO_RELOAD_EN
                    if (r_reload_q == '0) begin
                        w_state_d = ST_IDLE;
                    end
`else
                    w_state_d = ST_IDLE;
`endif
                end else if (r_count_q != '0) begin
                    w_count_d = r_count_q - c_COUNT_ONE;
                end else begin
                    // Zero while running: in auto-reload this is the tick
                    // after reaching zero, so restart from the reload value.
                    // In one-shot builds it is unreachable; restore the last
                    // loaded value and park in IDLE.
                    w_count_d = r_reload_q;
`ifndef AUTO_RELOAD_EN
                    w_state_d = ST_IDLE;
`endif
                end
            end else begin
                w_presc_d = r_presc_q + c_PRESC_ONE;
            end
        end
    end

    zero_det #(
        .WIDTH (WIDTH)
    ) u_zero_det (
        .i_value (r_count_q),
        .o_zero  (zero_out)
    );

    assign count_out = r_count_q;
    assign done      = r_done_q;
    assign busy      = (r_state_q == ST_RUN);

endmodule : zero_countdown_timer
`default_nettype wire

// File: tb/tb_zero_countdown_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_zero_countdown_timer
// Description : Self-checking bench for zero_countdown_timer. One instance
//               with TICK_DIV=1 (table-driven) and one with TICK_DIV=4
//               (hand-written prescaler/pause/reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_zero_countdown_timer;

    localparam int W = 8;
`ifdef AUTO_RELOAD_EN
    localparam bit c_AUTO = 1'b1;
`else
    localparam bit c_AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic         a_load, a_start, a_pause;
    logic [W-1:0] a_val, a_count;
    logic         a_zero, a_done, a_busy;

    logic         b_load, b_start, b_pause;
    logic [W-1:0] b_val, b_count;
    logic         b_zero, b_done, b_busy;

    zero_countdown_timer #(.WIDTH(W), .TICK_DIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .load(a_load), .load_val(a_val),
        .start(a_start), .pause(a_pause), .count_out(a_count),
        .zero_out(a_zero), .done(a_done), .busy(a_busy)
    );

    zero_countdown_timer #(.WIDTH(W), .TICK_DIV(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .load(b_load), .load_val(b_val),
        .start(b_start), .pause(b_pause), .count_out(b_count),
        .zero_out(b_zero), .done(b_done), .busy(b_busy)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic         ld;
        logic [W-1:0] val;
        logic         st;
        logic         ps;
        logic [W-1:0] c;
        logic         z;
        logic         d;
        logic         b;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ld, input logic [W-1:0] val,
                                input logic st, input logic ps,
                                input logic [W-1:0] c, input logic z,
                                input logic d, input logic b);
        vec_t v;
        v.ld = ld; v.val = val; v.st = st; v.ps = ps;
        v.c = c; v.z = z; v.d = d; v.b = b;
        return v;
    endfunction

    // Compares {count, zero, done, busy}
    task automatic check(input string name, input logic [W+2:0] act,
                         input logic [W+2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual count=%h zero=%b done=%b busy=%b, required count=%h zero=%b done=%b busy=%b",
                     name, act[W+2:3], act[2], act[1], act[0],
                     exp[W+2:3], exp[2], exp[1], exp[0]);
        end
    endtask

    task automatic step_a(input logic ld, input logic [W-1:0] val,
                          input logic st, input logic ps);
        @(negedge clk);
        a_load = ld; a_val = val; a_start = st; a_pause = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic ld, input logic [W-1:0] val,
                          input logic st, input logic ps);
        @(negedge clk);
        b_load = ld; b_val = val; b_start = st; b_pause = ps;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W+2:0] exp_of(input logic [W-1:0] c, input logic z,
                                            input logic d, input logic b);
        return {c, z, d, b};
    endfunction

    initial begin
        rst_n = 1'b0;
        a_load = 0; a_val = '0; a_start = 0; a_pause = 0;
        b_load = 0; b_val = '0; b_start = 0; b_pause = 0;

        // Vectors for the TICK_DIV=1 instance: inputs then state after the edge
        tbl.push_back(mk(1, 8'd5, 0, 0, 8'd5, 0, 0, 0)); // load 5
        tbl.push_back(mk(0, 8'd0, 1, 0, 8'd5, 0, 0, 1)); // start
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd4, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd3, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd2, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd1, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd0, 1, 1, c_AUTO)); // reaches zero
        tbl.push_back(mk(0, 8'd0, 0, 0, c_AUTO ? 8'd5 : 8'd0, !c_AUTO, 0, c_AUTO));
        tbl.push_back(mk(1, 8'd0, 0, 0, 8'd0, 1, 0, 0)); // load 0
        tbl.push_back(mk(0, 8'd0, 1, 0, 8'd0, 1, 1, 0)); // start at zero -> done only
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd0, 1, 0, 0)); // single pulse
        tbl.push_back(mk(1, 8'd3, 1, 0, 8'd3, 0, 0, 0)); // load+start: load wins
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd3, 0, 0, 0)); // no decrement in IDLE
        tbl.push_back(mk(0, 8'd0, 1, 0, 8'd3, 0, 0, 1)); // start
        tbl.push_back(mk(0, 8'd0, 1, 0, 8'd2, 0, 0, 1)); // start in RUN ignored
        tbl.push_back(mk(1, 8'd9, 0, 0, 8'd9, 0, 0, 0)); // load in RUN -> IDLE
        tbl.push_back(mk(0, 8'd0, 1, 0, 8'd9, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 1, 8'd9, 0, 0, 1)); // paused
        tbl.push_back(mk(0, 8'd0, 0, 1, 8'd9, 0, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 0, 8'd8, 0, 0, 1)); // resumed
        tbl.push_back(mk(1, 8'd0, 0, 0, 8'd0, 1, 0, 0)); // back to idle

        // Reset state, sampled while reset is asserted
        #12;
        check("reset_a", {a_count, a_zero, a_done, a_busy}, exp_of(8'd0, 1, 0, 0));
        check("reset_b", {b_count, b_zero, b_done, b_busy}, exp_of(8'd0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step_a(tbl[i].ld, tbl[i].val, tbl[i].st, tbl[i].ps);
            check($sformatf("vec_%0d", i), {a_count, a_zero, a_done, a_busy},
                  exp_of(tbl[i].c, tbl[i].z, tbl[i].d, tbl[i].b));
        end
        step_a(0, 8'd0, 0, 0);

        // TICK_DIV=4: decrements 4 cycles apart, 3-cycle pause in the middle
        step_b(1, 8'd2, 0, 0);
        check("div4_load", {b_count, b_zero, b_done, b_busy}, exp_of(8'd2, 0, 0, 0));
        step_b(0, 8'd0, 1, 0);
        check("div4_start", {b_count, b_zero, b_done, b_busy}, exp_of(8'd2, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            step_b(0, 8'd0, 0, 0);
            check($sformatf("div4_hold2_%0d", i), {b_count, b_zero, b_done, b_busy},
                  exp_of(8'd2, 0, 0, 1));
        end
        step_b(0, 8'd0, 0, 0);
        check("div4_dec1", {b_count, b_zero, b_done, b_busy}, exp_of(8'd1, 0, 0, 1));
        for (int i = 0; i < 3; i++) begin
            step_b(0, 8'd0, 0, 1);
            check($sformatf("div4_pause_%0d", i), {b_count, b_zero, b_done, b_busy},
                  exp_of(8'd1, 0, 0, 1));
        end
        for (int i = 0; i < 3; i++) begin
            step_b(0, 8'd0, 0, 0);
            check($sformatf("div4_hold1_%0d", i), {b_count, b_zero, b_done, b_busy},
                  exp_of(8'd1, 0, 0, 1));
        end
        step_b(0, 8'd0, 0, 0);
        check("div4_zero", {b_count, b_zero, b_done, b_busy}, exp_of(8'd0, 1, 1, c_AUTO));
        step_b(0, 8'd0, 0, 0);
        check("div4_after", {b_count, b_zero, b_done, b_busy}, exp_of(8'd0, 1, 0, c_AUTO));
        step_b(1, 8'd0, 0, 0);

        // Asynchronous reset while running at 0x80
        step_b(1, 8'h80, 0, 0);
        step_b(0, 8'd0, 1, 0);
        check("rst_run", {b_count, b_zero, b_done, b_busy}, exp_of(8'h80, 0, 0, 1));
        step_b(0, 8'd0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", {b_count, b_zero, b_done, b_busy}, exp_of(8'd0, 1, 0, 0));
        @(posedge clk);
        #1;
        check("rst_no_done", {b_count, b_zero, b_done, b_busy}, exp_of(8'd0, 1, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        b_start = 1'b0;

`ifdef AUTO_RELOAD_EN
        // Auto-reload: 3,2,1,0,3,2,1,0,3 with done on each 0 and busy held
        begin
            logic [W-1:0] seq [9];
            seq = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
            step_a(1, 8'd3, 0, 0);
            step_a(0, 8'd0, 1, 0);
            check("auto_start", {a_count, a_zero, a_done, a_busy}, exp_of(seq[0], 0, 0, 1));
            for (int i = 1; i < 9; i++) begin
                step_a(0, 8'd0, 0, 0);
                check($sformatf("auto_%0d", i), {a_count, a_zero, a_done, a_busy},
                      exp_of(seq[i], seq[i] == 8'd0, seq[i] == 8'd0, 1));
            end
            step_a(1, 8'd0, 0, 0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_zero_countdown_timer
`default_nettype wire
